// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory read port from the
// PC, keeps a one-word skid buffer for words returned under a downstream stall,
// and produces the IF/ID pipeline register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | request outstanding at pc; an ack delivers or skids the word
// HOLD    | word parked in skid buffer, no request; waits for stall release
// DISCARD | branch came mid-request; finish old request, drop its data,
//         | then redirect to the saved target
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  instr_op
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] skid_q;
    logic [31:0] tgt_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;

    logic [31:0] pc_plus4;

    // Unsigned add; wraps from 32'hFFFF_FFFC to zero.
    assign pc_plus4 = pc_q + 32'd4;

    // Request is a pure function of state; gated by rst so no request is seen
    // in any reset cycle, even the first one before the state is cleared.
    assign imem_req    = (state_q != HOLD) && !rst;
    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    // Bubbles always carry instr=0, so the opcode of an invalid slot is 0 (NOP).
    assign instr_op    = instr_q[31:26];

    // Fetch FSM, PC, skid buffer, saved branch target and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            skid_q  <= 32'h0;
            tgt_q   <= 32'h0;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
        end else begin
            // IF/ID default: flush beats stall, stall holds, otherwise bubble.
            // Delivered instructions override the bubble below.
            if (branch_taken) begin
                valid_q <= 1'b0;
                instr_q <= 32'h0;
                pc4_q   <= 32'h0;
            end else if (!stall) begin
                valid_q <= 1'b0;
                instr_q <= 32'h0;
                pc4_q   <= 32'h0;
            end

            unique case (state_q)
                FETCH: begin
                    if (branch_taken) begin
                        if (imem_ack) begin
                            pc_q <= branch_target;
                        end else begin
                            // Request cannot be withdrawn; remember where to go.
                            tgt_q   <= branch_target;
                            state_q <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_plus4;
                        if (stall) begin
                            skid_q  <= imem_rdata;
                            state_q <= HOLD;
                        end else begin
                            valid_q <= 1'b1;
                            instr_q <= imem_rdata;
                            pc4_q   <= pc_plus4;
                        end
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        pc_q    <= branch_target;
                        state_q <= FETCH;
                    end else if (!stall) begin
                        // pc already advanced past the skidded word.
                        valid_q <= 1'b1;
                        instr_q <= skid_q;
                        pc4_q   <= pc_q;
                        state_q <= FETCH;
                    end
                end

                DISCARD: begin
                    if (branch_taken) begin
                        tgt_q <= branch_target;
                    end
                    if (imem_ack) begin
                        // A branch arriving with the ack is the newest target.
                        pc_q    <= branch_taken ? branch_target : tgt_q;
                        state_q <= FETCH;
                    end
                end

                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Stimulus pushes each instruction it
// expects to reach IF/ID into a queue; a monitor pops and compares whenever
// the IF/ID register is freshly loaded with a valid instruction.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  instr_op;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic stall_seen = 1'b0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .instr_op     (instr_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        exp_q.push_back(e);
    endtask

    // Stall as seen by the DUT at the edge: a held register is not a new load.
    always @(posedge clk) stall_seen = stall;

    // Monitor: any freshly loaded valid IF/ID entry must match the queue head.
    always @(negedge clk) begin
        if (if_id_valid === 1'b1 && stall_seen === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got instr %h pc4 %h expected nothing", if_id_instr, if_id_pc4);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", if_id_instr, e.instr);
                check("sb_pc4", if_id_pc4, e.pc4);
                check("sb_op", {26'h0, instr_op}, {26'h0, e.instr[31:26]});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;

        // Reset
        @(negedge clk);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        check("rst_req2", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);

        // Zero-wait: lw then sw on consecutive cycles
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C08_0004;
        push(32'h8C08_0004, 32'h4);
        #1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("lw_op", {26'h0, instr_op}, 32'h23);
        check("lw_pc4", if_id_pc4, 32'h4);
        check("addr4", imem_addr, 32'h4);
        imem_rdata = 32'hAC09_0008;
        push(32'hAC09_0008, 32'h8);
        @(negedge clk);
        check("sw_op", {26'h0, instr_op}, 32'h2B);
        check("sw_pc4", if_id_pc4, 32'h8);

        // Ack under stall: 3 stalled cycles in HOLD, then skid word delivered
        imem_rdata = 32'h2042_0001; stall = 1'b1;
        push(32'h2042_0001, 32'hC);
        @(negedge clk);
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_req", {31'h0, imem_req}, 32'h0);
            check("hold_instr", if_id_instr, 32'hAC09_0008);
            check("hold_valid", {31'h0, if_id_valid}, 32'h1);
            if (i == 2) stall = 1'b0;
            @(negedge clk);
        end
        check("skid_valid", {31'h0, if_id_valid}, 32'h1);
        check("skid_instr", if_id_instr, 32'h2042_0001);
        check("after_hold_req", {31'h0, imem_req}, 32'h1);
        check("after_hold_addr", imem_addr, 32'hC);

        // Branch to 0x40 with a 2-wait-state request pending
        branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        branch_taken = 1'b0; branch_target = 32'h0;
        check("disc_flush_valid", {31'h0, if_id_valid}, 32'h0);
        check("disc_flush_op", {26'h0, instr_op}, 32'h0);
        check("disc_req", {31'h0, imem_req}, 32'h1);
        check("disc_addr_w1", imem_addr, 32'hC);
        @(negedge clk);
        check("disc_addr_w2", imem_addr, 32'hC);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("redirect_addr", imem_addr, 32'h40);
        check("redirect_req", {31'h0, imem_req}, 32'h1);
        check("drop_valid", {31'h0, if_id_valid}, 32'h0);

        // Branch and stall together while a skid word is pending
        imem_rdata = 32'h8C0A_000C;
        push(32'h8C0A_000C, 32'h44);
        @(negedge clk);
        check("addr44", imem_addr, 32'h44);
        imem_rdata = 32'h1111_1111; stall = 1'b1;
        @(negedge clk);
        check("hold2_req", {31'h0, imem_req}, 32'h0);
        check("hold2_instr", if_id_instr, 32'h8C0A_000C);
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        @(negedge clk);
        check("bs_flush_valid", {31'h0, if_id_valid}, 32'h0);
        check("bs_flush_op", {26'h0, instr_op}, 32'h0);
        check("bs_addr", imem_addr, 32'hFFFF_FFF8);
        check("bs_req", {31'h0, imem_req}, 32'h1);

        // PC wrap: fetches at FFFF_FFF8, FFFF_FFFC, then 0
        branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hAC0B_0010;
        push(32'hAC0B_0010, 32'hFFFF_FFFC);
        @(negedge clk);
        check("addr_fffc", imem_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'h8C0C_0014;
        push(32'h8C0C_0014, 32'h0);
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_valid", {31'h0, if_id_valid}, 32'h1);

        // Reset in the middle of DISCARD
        branch_taken = 1'b1; branch_target = 32'h200; imem_rdata = 32'h0;
        @(negedge clk);
        check("addr200", imem_addr, 32'h200);
        imem_ack = 1'b0; branch_target = 32'h300;
        @(negedge clk);
        check("disc2_addr", imem_addr, 32'h200);
        branch_taken = 1'b0; branch_target = 32'h0; rst = 1'b1;
        #1;
        check("rst_cycle_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_req", {31'h0, imem_req}, 32'h0);
        check("rst2_valid", {31'h0, if_id_valid}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        @(negedge clk);
        check("rst_ack_ignored_addr", imem_addr, 32'h0);
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        check("resume_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        check("resume_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h8C0D_0018;
        push(32'h8C0D_0018, 32'h4);
        @(negedge clk);
        check("resume_next_addr", imem_addr, 32'h4);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
